// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with one synchronous write port,
// two combinational read ports (A/B), optional same-cycle write-to-read
// bypass, a per-register pending scoreboard (lock/clear) and a
// written-since-reset vector.
//
// Interface timing: write/lock are sampled on the rising clk edge; all read
// outputs (data_out_x, busy_x, pending_vec, written_vec) are combinational
// views of current state plus, when BYPASS != 0, the write being presented
// this cycle. There is no valid/ready handshake: reads have zero latency.
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] writenum,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] readnum_a,
    output logic [DATA_W-1:0] data_out_a,
    input  logic [ADDR_W-1:0] readnum_b,
    output logic [DATA_W-1:0] data_out_b,
    input  logic              lock,
    input  logic [ADDR_W-1:0] locknum,
    output logic              busy_a,
    output logic              busy_b,
    output logic [NREGS-1:0]  pending_vec,
    output logic [NREGS-1:0]  written_vec
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending_q;
    logic [NREGS-1:0]  written_q;

    // Per-port lookup results; *_hit is 0 when the index is out of range.
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              pend_a, pend_b;
    logic              hit_a, hit_b;

    // Register storage: a write to an index outside 0..NREGS-1 matches no
    // entry in the decode loop and is therefore dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (write) begin
            for (int i = 0; i < NREGS; i++) begin
                if (writenum == ADDR_W'(i)) regs[i] <= data_in;
            end
        end
    end

    // Pending and written flags: a write clears pending, a lock sets it; the
    // lock assignment comes second so it wins on a same-index collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            written_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (write && (writenum == ADDR_W'(i))) begin
                    written_q[i] <= 1'b1;
                    pending_q[i] <= 1'b0;
                end
                if (lock && (locknum == ADDR_W'(i))) begin
                    pending_q[i] <= 1'b1;
                end
            end
        end
    end

    // Port A/B lookup: decode the index against stored contents and flags.
    always_comb begin
        rd_a   = '0;
        rd_b   = '0;
        pend_a = 1'b0;
        pend_b = 1'b0;
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (readnum_a == ADDR_W'(i)) begin
                rd_a   = regs[i];
                pend_a = pending_q[i];
                hit_a  = 1'b1;
            end
            if (readnum_b == ADDR_W'(i)) begin
                rd_b   = regs[i];
                pend_b = pending_q[i];
                hit_b  = 1'b1;
            end
        end
    end

    // Port A output: forward data_in when bypassing a same-index write; the
    // register is then only busy if it is being re-locked in the same cycle.
    always_comb begin
        data_out_a = '0;
        busy_a     = 1'b0;
        if (reset_n) begin
            if ((BYPASS != 0) && write && hit_a && (writenum == readnum_a)) begin
                data_out_a = data_in;
                busy_a     = lock && (locknum == readnum_a);
            end else begin
                data_out_a = rd_a;
                busy_a     = pend_a;
            end
        end
    end

    // Port B output: same bypass rule as port A.
    always_comb begin
        data_out_b = '0;
        busy_b     = 1'b0;
        if (reset_n) begin
            if ((BYPASS != 0) && write && hit_b && (writenum == readnum_b)) begin
                data_out_b = data_in;
                busy_b     = lock && (locknum == readnum_b);
            end else begin
                data_out_b = rd_b;
                busy_b     = pend_b;
            end
        end
    end

    assign pending_vec = pending_q;
    assign written_vec = written_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with three instances
// (default BYPASS=1, BYPASS=0, and NREGS=6/DATA_W=32). The driver applies
// inputs just after each rising edge and queues expected values; the monitor
// compares them on the following falling edge.
module tb_regfile_mp;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // ---------------- main / BYPASS=0 inputs (shared) ----------------
    logic        write, lock;
    logic [2:0]  writenum, readnum_a, readnum_b, locknum;
    logic [15:0] data_in;

    logic [15:0] m_a, m_b;
    logic        m_busy_a, m_busy_b;
    logic [7:0]  m_pend, m_wr;

    logic [15:0] z_a, z_b;
    logic        z_busy_a, z_busy_b;
    logic [7:0]  z_pend, z_wr;

    // ---------------- NREGS=6 instance inputs ----------------
    logic        w6, lock6;
    logic [2:0]  wn6, ra6, rb6, ln6;
    logic [31:0] din6;
    logic [31:0] s_a, s_b;
    logic        s_busy_a, s_busy_b;
    logic [5:0]  s_pend, s_wr;

    regfile_mp dut (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum),
        .data_in(data_in), .readnum_a(readnum_a), .data_out_a(m_a),
        .readnum_b(readnum_b), .data_out_b(m_b), .lock(lock), .locknum(locknum),
        .busy_a(m_busy_a), .busy_b(m_busy_b), .pending_vec(m_pend), .written_vec(m_wr)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .write(write), .writenum(writenum),
        .data_in(data_in), .readnum_a(readnum_a), .data_out_a(z_a),
        .readnum_b(readnum_b), .data_out_b(z_b), .lock(lock), .locknum(locknum),
        .busy_a(z_busy_a), .busy_b(z_busy_b), .pending_vec(z_pend), .written_vec(z_wr)
    );

    regfile_mp #(.NREGS(6), .ADDR_W(3), .DATA_W(32)) dut6 (
        .clk(clk), .reset_n(reset_n), .write(w6), .writenum(wn6),
        .data_in(din6), .readnum_a(ra6), .data_out_a(s_a),
        .readnum_b(rb6), .data_out_b(s_b), .lock(lock6), .locknum(ln6),
        .busy_a(s_busy_a), .busy_b(s_busy_b), .pending_vec(s_pend), .written_vec(s_wr)
    );

    // ---------------- scoreboard ----------------
    localparam int SEL_A = 0, SEL_B = 1, SEL_BUSY_A = 2, SEL_BUSY_B = 3,
                   SEL_PEND = 4, SEL_WR = 5, SEL_NB_A = 6, SEL_S_A = 7,
                   SEL_S_WR = 8, SEL_S_B = 9;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] get_act(input int sel);
        case (sel)
            SEL_A:      return {16'h0, m_a};
            SEL_B:      return {16'h0, m_b};
            SEL_BUSY_A: return {31'h0, m_busy_a};
            SEL_BUSY_B: return {31'h0, m_busy_b};
            SEL_PEND:   return {24'h0, m_pend};
            SEL_WR:     return {24'h0, m_wr};
            SEL_NB_A:   return {16'h0, z_a};
            SEL_S_A:    return s_a;
            SEL_S_WR:   return {26'h0, s_wr};
            SEL_S_B:    return s_b;
            default:    return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    // Monitor: drain every queued expectation on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            automatic string       tag = tag_q.pop_front();
            automatic int          sel = sel_q.pop_front();
            automatic logic [31:0] ev  = exp_q.pop_front();
            automatic logic [31:0] av  = get_act(sel);
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL %s: got %h expected %h (t=%0t)", tag, av, ev, $time);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        write = 0; lock = 0; writenum = 0; readnum_a = 0; readnum_b = 0;
        locknum = 0; data_in = 0;
        w6 = 0; lock6 = 0; wn6 = 0; ra6 = 0; rb6 = 0; ln6 = 0; din6 = 0;

        // Reset held: outputs zero even with a bypassing write presented.
        step();
        write = 1; writenum = 0; data_in = 16'hBEEF; readnum_a = 0;
        expect_val("rst_held_a", SEL_A, 0);
        expect_val("rst_held_pend", SEL_PEND, 0);
        expect_val("rst_held_wr", SEL_WR, 0);
        step();
        write = 0; data_in = 0;
        reset_n = 1'b1;

        // All indices read zero after reset on both ports.
        for (int i = 0; i < 8; i++) begin
            step();
            readnum_a = 3'(i);
            readnum_b = 3'(7 - i);
            expect_val("init_a", SEL_A, 0);
            expect_val("init_b", SEL_B, 0);
        end
        expect_val("init_pend", SEL_PEND, 32'h00);
        expect_val("init_wr", SEL_WR, 32'h00);

        // Basic writes r0, r4.
        step(); write = 1; writenum = 0; data_in = 16'h5555; readnum_a = 7; readnum_b = 7;
        step(); writenum = 4; data_in = 16'hC3A5;
        step(); write = 0; readnum_a = 0; readnum_b = 4;
        expect_val("wr_r0", SEL_A, 32'h5555);
        expect_val("wr_r4", SEL_B, 32'hC3A5);
        expect_val("wr_vec_11", SEL_WR, 32'h11);
        step(); data_in = 16'hFFFF; writenum = 4;
        expect_val("nowrite_before", SEL_B, 32'hC3A5);
        step();
        expect_val("nowrite_after", SEL_B, 32'hC3A5);

        // Bypass: BYPASS=1 forwards immediately, BYPASS=0 after the edge.
        step(); write = 1; writenum = 5; data_in = 16'h1234; readnum_a = 5;
        expect_val("byp1_before", SEL_A, 32'h1234);
        expect_val("byp0_before", SEL_NB_A, 32'h0000);
        step(); write = 0; data_in = 16'h0;
        expect_val("byp1_after", SEL_A, 32'h1234);
        expect_val("byp0_after", SEL_NB_A, 32'h1234);

        // Lock r3, then clear via write, then lock+write same cycle.
        step(); lock = 1; locknum = 3; readnum_a = 3; readnum_b = 3;
        expect_val("lock_before", SEL_BUSY_A, 0);
        step(); lock = 0;
        expect_val("lock_busy_a", SEL_BUSY_A, 1);
        expect_val("lock_busy_b", SEL_BUSY_B, 1);
        expect_val("lock_pend_08", SEL_PEND, 32'h08);
        step(); write = 1; writenum = 3; data_in = 16'h00FF;
        expect_val("clr_byp_busy", SEL_BUSY_A, 0);
        expect_val("clr_byp_data", SEL_A, 32'h00FF);
        step(); write = 0;
        expect_val("clr_pend_00", SEL_PEND, 32'h00);
        expect_val("clr_busy_a", SEL_BUSY_A, 0);
        expect_val("clr_data", SEL_A, 32'h00FF);
        expect_val("clr_wr_39", SEL_WR, 32'h39);
        step(); write = 1; lock = 1; writenum = 3; locknum = 3; data_in = 16'hABCD;
        expect_val("wl_byp_data", SEL_A, 32'hABCD);
        expect_val("wl_byp_busy", SEL_BUSY_A, 1);
        step(); write = 0; lock = 0;
        expect_val("wl_pend_08", SEL_PEND, 32'h08);
        expect_val("wl_data", SEL_A, 32'hABCD);
        expect_val("wl_busy", SEL_BUSY_A, 1);

        // Write and lock to different indices; then re-lock r6.
        step(); write = 1; writenum = 1; data_in = 16'h1111; lock = 1; locknum = 6;
        step(); write = 0; lock = 0; readnum_a = 1; readnum_b = 6;
        expect_val("diff_data", SEL_A, 32'h1111);
        expect_val("diff_busy_b", SEL_BUSY_B, 1);
        expect_val("diff_pend_48", SEL_PEND, 32'h48);
        expect_val("diff_wr_3b", SEL_WR, 32'h3B);
        step(); lock = 1; locknum = 6;
        step(); lock = 0;
        expect_val("relock_pend_48", SEL_PEND, 32'h48);

        // NREGS=6 instance: out-of-range write/read.
        step(); w6 = 1; wn6 = 2; din6 = 32'hDEAD_BEEF;
        step(); wn6 = 7; din6 = 32'h1234_5678; rb6 = 7;
        expect_val("n6_oor_byp", SEL_S_B, 0);
        step(); w6 = 0; ra6 = 2; rb6 = 7;
        expect_val("n6_r2", SEL_S_A, 32'hDEAD_BEEF);
        expect_val("n6_r7", SEL_S_B, 0);
        expect_val("n6_wr_04", SEL_S_WR, 32'h04);
        step(); w6 = 1; wn6 = 6; din6 = 32'hCAFE_F00D;
        step(); w6 = 0; ra6 = 6;
        expect_val("n6_r6", SEL_S_A, 0);
        expect_val("n6_wr_still", SEL_S_WR, 32'h04);

        // Asynchronous reset pulse between edges, with a write presented.
        step();
        reset_n = 1'b0;
        write = 1; writenum = 2; data_in = 16'h7777; readnum_a = 2; readnum_b = 3;
        ra6 = 2;
        expect_val("arst_a", SEL_A, 0);
        expect_val("arst_busy_b", SEL_BUSY_B, 0);
        expect_val("arst_pend", SEL_PEND, 0);
        expect_val("arst_wr", SEL_WR, 0);
        expect_val("arst_n6", SEL_S_A, 0);
        #6;
        reset_n = 1'b1;
        write = 0;
        step(); readnum_a = 3; readnum_b = 0;
        expect_val("post_rst_r3", SEL_A, 0);
        expect_val("post_rst_r0", SEL_B, 0);
        expect_val("post_rst_wr", SEL_WR, 0);

        step();
        step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
